datapath_sequencer: RTL

- Multi-cycle controller for the 16-bit register-file/ALU datapath.
- Accepts one two-address command at a time over a valid/ready handshake.
- Drives the A/B operand read-mux selects (4-bit, 16:1), the immediate-vs-register operand select and the ALU opcode.
- Captures the ALU result and issues a one-hot register write enable plus a completion pulse.

---
 rtl/datapath_sequencer_if.sv | 38 +++
 rtl/datapath_sequencer.sv | 124 ++++++++++++
 2 files changed

// File: rtl/datapath_sequencer_if.sv
// Command handshake and datapath control bundle shared by the datapath
// sequencer (slave) and its command source / ALU environment (master).
interface datapath_sequencer_if #(
   parameter int DATA_W = 16,
   parameter int SEL_W  = 4,
   parameter int OP_W   = 4
);
   logic                    cmd_valid;
   logic                    cmd_ready;
   logic [OP_W-1:0]         cmd_op;
   logic [SEL_W-1:0]        cmd_dst;
   logic [SEL_W-1:0]        cmd_src;
   logic                    cmd_use_imm;
   logic [DATA_W-1:0]       cmd_imm;
   logic [SEL_W-1:0]        rsel_a;
   logic [SEL_W-1:0]        rsel_b;
   logic                    bsel;
   logic [DATA_W-1:0]       imm_out;
   logic [OP_W-1:0]         alu_op;
   logic [DATA_W-1:0]       alu_result;
   logic [(2**SEL_W)-1:0]   wr_en;
   logic [DATA_W-1:0]       wr_data;
   logic                    done;
   logic                    busy;
   logic [15:0]             cmd_count;

   modport master (
      output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_use_imm, cmd_imm, alu_result,
      input  cmd_ready, rsel_a, rsel_b, bsel, imm_out, alu_op, wr_en, wr_data,
             done, busy, cmd_count
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_use_imm, cmd_imm, alu_result,
      output cmd_ready, rsel_a, rsel_b, bsel, imm_out, alu_op, wr_en, wr_data,
             done, busy, cmd_count
   );
endinterface

// File: rtl/datapath_sequencer.sv
// Four-state controller (IDLE/READ/EXEC/WB) that steers the register-file
// read muxes and ALU for one two-address command, then writes the result back.
module datapath_sequencer #(
   parameter int              DATA_W = 16,
   parameter int              SEL_W  = 4,
   parameter int              OP_W   = 4,
   parameter logic [OP_W-1:0] OP_NOP = 4'hF,
   parameter logic [OP_W-1:0] OP_CMP = 4'hB
) (
   input  logic                  clk,
   input  logic                  reset_n,
   datapath_sequencer_if.slave   bus
);
   localparam int WR_W = 2**SEL_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic                cmd_ready_s;
   logic                accept_s;
   logic                suppress_wb_s;

   logic [SEL_W-1:0]    rsel_a_r;
   logic [SEL_W-1:0]    rsel_b_r;
   logic                bsel_r;
   logic [DATA_W-1:0]   imm_out_r;
   logic [OP_W-1:0]     alu_op_r;
   logic [WR_W-1:0]     wr_en_r;
   logic [DATA_W-1:0]   wr_data_r;
   logic                done_r;
   logic [15:0]         cmd_count_r;

   function automatic logic [WR_W-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
      logic [WR_W-1:0] oh;
      oh      = {WR_W{1'b0}};
      oh[sel] = 1'b1;
      return oh;
   endfunction

   // Next-state decode plus the state-derived handshake outputs.
   always_comb begin
      state_nxt_s   = state_r;
      cmd_ready_s   = 1'b0;
      accept_s      = 1'b0;
      suppress_wb_s = (alu_op_r == OP_NOP) || (alu_op_r == OP_CMP);
      case (state_r)
         ST_IDLE: begin
            cmd_ready_s = 1'b1;
            if (bus.cmd_valid) begin
               accept_s    = 1'b1;
               state_nxt_s = ST_READ;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_READ: state_nxt_s = ST_EXEC;
         ST_EXEC: state_nxt_s = ST_WB;
         ST_WB:   state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Command capture; selects hold between commands so the datapath stays quiet.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsel_a_r  <= {SEL_W{1'b0}};
         rsel_b_r  <= {SEL_W{1'b0}};
         bsel_r    <= 1'b0;
         imm_out_r <= {DATA_W{1'b0}};
         alu_op_r  <= {OP_W{1'b0}};
      end else if (accept_s) begin
         rsel_a_r  <= bus.cmd_dst;
         rsel_b_r  <= bus.cmd_src;
         bsel_r    <= bus.cmd_use_imm;
         imm_out_r <= bus.cmd_imm;
         alu_op_r  <= bus.cmd_op;
      end
   end

   // Result capture and the one-cycle writeback/completion strobes shown in WB.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_data_r   <= {DATA_W{1'b0}};
         wr_en_r     <= {WR_W{1'b0}};
         done_r      <= 1'b0;
         cmd_count_r <= 16'h0000;
      end else if (state_r == ST_EXEC) begin
         wr_data_r   <= bus.alu_result;
         wr_en_r     <= suppress_wb_s ? {WR_W{1'b0}} : sel_onehot(rsel_a_r);
         done_r      <= 1'b1;
         cmd_count_r <= cmd_count_r + 16'h0001;
      end else begin
         wr_en_r     <= {WR_W{1'b0}};
         done_r      <= 1'b0;
      end
   end

   assign bus.cmd_ready = cmd_ready_s;
   assign bus.busy      = ~cmd_ready_s;
   assign bus.rsel_a    = rsel_a_r;
   assign bus.rsel_b    = rsel_b_r;
   assign bus.bsel      = bsel_r;
   assign bus.imm_out   = imm_out_r;
   assign bus.alu_op    = alu_op_r;
   assign bus.wr_en     = wr_en_r;
   assign bus.wr_data   = wr_data_r;
   assign bus.done      = done_r;
   assign bus.cmd_count = cmd_count_r;
endmodule
